// File: rtl/alu_serial_rx.sv
// Serial command receiver: deserialises NUM_ARGS argument words plus a command frame and
// presents a classified packet on a valid/ready port. Optional idle timeout: ALU_RX_TIMEOUT_EN.
module alu_serial_rx #(
    parameter int NUM_ARGS    = 2,
    parameter int ARG_BYTES   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_ARGS*8*ARG_BYTES-1:0] out_args,
    output logic [2:0]                      out_op,
    output logic [2:0]                      out_status,
    output logic                            ovf
);
    localparam int ARG_W = 8 * ARG_BYTES;
    localparam int TOTAL = NUM_ARGS * ARG_BYTES;
    localparam int PKT_W = NUM_ARGS * ARG_W;
    localparam logic [7:0] TOTAL_B = 8'(TOTAL);

    if (NUM_ARGS < 1 || NUM_ARGS > 8 || ARG_BYTES < 1 || ARG_BYTES > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("alu_serial_rx: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_BITS, S_EVAL} state_t;

    state_t             state;
    logic [3:0]         bit_cnt;
    logic [8:0]         shift;
    logic [7:0]         byte_cnt;
    logic [PKT_W-1:0]   args_q;
    logic [2:0]         op_q;
    logic [3:0]         crc_q;
    logic [3:0]         crc_rx_q;
    logic               abort_q;
    logic [3:0]         crc_calc;
    logic [2:0]         status_n;

`ifdef ALU_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]    idle_cnt;
`endif

    // CRC-4, x^4+x+1, one message bit per step, MSB first
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic b);
        logic fb;
        fb = crc[3] ^ b;
        return {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    endfunction

    function automatic logic [3:0] crc4_byte(input logic [3:0] crc, input logic [7:0] d);
        logic [3:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) c = crc4_step(c, d[i]);
        return c;
    endfunction

    function automatic logic [3:0] crc4_tail(input logic [3:0] crc, input logic [2:0] op);
        logic [3:0] c;
        c = crc4_step(crc, 1'b1);
        for (int i = 2; i >= 0; i--) c = crc4_step(c, op[i]);
        return c;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101;
    endfunction

    always_comb begin
        crc_calc = crc4_tail(crc_q, op_q);
        status_n = 3'b000;
        if (abort_q || byte_cnt != TOTAL_B)
            status_n = 3'b001;
        else if (crc_calc != crc_rx_q)
            status_n = 3'b010;
        else if (!op_legal(op_q))
            status_n = 3'b100;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 9'd0;
            byte_cnt   <= 8'd0;
            args_q     <= '0;
            op_q       <= 3'd0;
            crc_q      <= 4'd0;
            crc_rx_q   <= 4'd0;
            abort_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_args   <= '0;
            out_op     <= 3'd0;
            out_status <= 3'd0;
            ovf        <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!sin) begin
                        state   <= S_BITS;
                        bit_cnt <= 4'd0;
`ifdef ALU_RX_TIMEOUT_EN
                        idle_cnt <= '0;
                    end else if (byte_cnt != 8'd0) begin
                        if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                            abort_q  <= 1'b1;
                            idle_cnt <= '0;
                            state    <= S_EVAL;
                        end else begin
                            idle_cnt <= idle_cnt + TO_W'(1);
                        end
`endif
                    end
                end

                // type bit lands in shift[8], payload in shift[7:0]; sin is the stop bit at count 9
                S_BITS: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {shift[7:0], sin};
                    if (bit_cnt == 4'd9) begin
                        if (!sin) begin
                            abort_q <= 1'b1;
                            state   <= S_EVAL;
                        end else if (shift[8]) begin
                            op_q     <= shift[6:4];
                            crc_rx_q <= shift[3:0];
                            state    <= S_EVAL;
                        end else begin
                            for (int i = 0; i < TOTAL; i++) begin
                                if (byte_cnt == 8'(i))
                                    args_q[(i / ARG_BYTES) * ARG_W + (ARG_BYTES - 1 - i % ARG_BYTES) * 8 +: 8] <= shift[7:0];
                            end
                            if (byte_cnt < TOTAL_B)
                                crc_q <= crc4_byte(crc_q, shift[7:0]);
                            if (byte_cnt != 8'hFF)
                                byte_cnt <= byte_cnt + 8'd1;
                            state <= S_IDLE;
                        end
                    end
                end

                // a full slot with no handshake this cycle loses the new packet
                S_EVAL: begin
                    if (!out_valid || out_ready) begin
                        out_valid  <= 1'b1;
                        out_args   <= args_q;
                        out_op     <= op_q;
                        out_status <= status_n;
                    end else begin
                        ovf <= 1'b1;
                    end
                    args_q   <= '0;
                    byte_cnt <= 8'd0;
                    crc_q    <= 4'd0;
                    crc_rx_q <= 4'd0;
                    op_q     <= 3'd0;
                    abort_q  <= 1'b0;
                    state    <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_rx.sv
// Bench for alu_serial_rx: two instances (2x32-bit and 3x16-bit args), queued expectations
// from a bit-level reference model, and a negedge monitor that checks every delivered packet.
module tb_alu_serial_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sin_v [2];
    logic        rdy_v [2];
    logic        rst_v [2];
    logic        valid_v [2];
    logic [2:0]  op_v [2];
    logic [2:0]  st_v [2];
    logic        ovf_v [2];
    logic [63:0] args_v [2];
    logic        valid0, valid1, ovf0, ovf1;
    logic [2:0]  op0, op1, st0, st1;
    logic [63:0] args0;
    logic [47:0] args1;

    alu_serial_rx #(.NUM_ARGS(2), .ARG_BYTES(4), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst_v[0]), .sin(sin_v[0]), .out_valid(valid0), .out_ready(rdy_v[0]),
        .out_args(args0), .out_op(op0), .out_status(st0), .ovf(ovf0));

    alu_serial_rx #(.NUM_ARGS(3), .ARG_BYTES(2), .TIMEOUT_CYC(64)) dut3 (
        .clk(clk), .rst(rst_v[1]), .sin(sin_v[1]), .out_valid(valid1), .out_ready(rdy_v[1]),
        .out_args(args1), .out_op(op1), .out_status(st1), .ovf(ovf1));

    assign valid_v[0] = valid0;
    assign valid_v[1] = valid1;
    assign op_v[0] = op0;
    assign op_v[1] = op1;
    assign st_v[0] = st0;
    assign st_v[1] = st1;
    assign ovf_v[0] = ovf0;
    assign ovf_v[1] = ovf1;
    assign args_v[0] = args0;
    assign args_v[1] = {16'h0000, args1};

    typedef struct packed {
        logic [63:0] args;
        logic [2:0]  op;
        logic [2:0]  st;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [7:0]  tx_bytes[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stop_cyc = 0;
    int          pop_cyc [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h", nm, inst, act, exp);
        end
    endtask

    function automatic int na_of(input int inst);
        return (inst == 0) ? 2 : 3;
    endfunction

    function automatic int ab_of(input int inst);
        return (inst == 0) ? 4 : 2;
    endfunction

    // arg k is bytes k*ab..k*ab+ab-1 read MSB first; bytes never received count as zero
    function automatic logic [63:0] model_args(input int inst, input int n);
        logic [63:0] flat;
        logic [63:0] word;
        int idx;
        flat = 64'd0;
        for (int k = 0; k < na_of(inst); k++) begin
            word = 64'd0;
            for (int j = 0; j < ab_of(inst); j++) begin
                idx = k * ab_of(inst) + j;
                word = (word << 8) | ((idx < n) ? 64'(tx_bytes[idx]) : 64'd0);
            end
            flat = flat | (word << (k * 8 * ab_of(inst)));
        end
        return flat;
    endfunction

    // remainder of (message * x^4) divided by x^4+x+1 via polynomial long division
    function automatic logic [3:0] model_crc(input int inst, input logic [2:0] op);
        bit         msg[$];
        logic [4:0] rem;
        int         total;
        total = na_of(inst) * ab_of(inst);
        for (int i = 0; i < total && i < tx_bytes.size(); i++)
            for (int b = 7; b >= 0; b--) msg.push_back(tx_bytes[i][b]);
        msg.push_back(1'b1);
        for (int b = 2; b >= 0; b--) msg.push_back(op[b]);
        for (int b = 0; b < 4; b++) msg.push_back(1'b0);
        rem = 5'd0;
        for (int m = 0; m < msg.size(); m++) begin
            rem = {rem[3:0], msg[m]};
            if (rem[4]) rem = rem ^ 5'b10011;
        end
        return rem[3:0];
    endfunction

    task automatic push_exp(input int inst, input logic [63:0] a, input logic [2:0] op, input logic [2:0] st);
        exp_t e;
        e.args = a;
        e.op   = op;
        e.st   = st;
        if (inst == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drive_bit(input int inst, input logic b);
        sin_v[inst] = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int inst, input logic typ, input logic [7:0] pl, input logic stp);
        drive_bit(inst, 1'b0);
        drive_bit(inst, typ);
        for (int b = 7; b >= 0; b--) drive_bit(inst, pl[b]);
        drive_bit(inst, stp);
        stop_cyc = cyc;
        drive_bit(inst, 1'b1);
        drive_bit(inst, 1'b1);
    endtask

    task automatic send_pkt(input int inst, input logic [2:0] op, input logic [3:0] flip,
                            input int bad_idx, input bit push, input int first);
        int total;
        int n;
        logic [3:0] crc;
        logic [2:0] st;
        total = na_of(inst) * ab_of(inst);
        n = tx_bytes.size();
        for (int i = first; i < n; i++) begin
            if (i == bad_idx) begin
                if (push) push_exp(inst, model_args(inst, (i < total) ? i : total), 3'b000, 3'b001);
                send_frame(inst, 1'b0, tx_bytes[i], 1'b0);
                return;
            end
            send_frame(inst, 1'b0, tx_bytes[i], 1'b1);
        end
        crc = model_crc(inst, op) ^ flip;
        if (n != total) st = 3'b001;
        else if (crc != model_crc(inst, op)) st = 3'b010;
        else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) st = 3'b100;
        else st = 3'b000;
        if (push) push_exp(inst, model_args(inst, (n < total) ? n : total), op, st);
        send_frame(inst, 1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    task automatic load_counting(input int inst);
        tx_bytes.delete();
        for (int k = 0; k < na_of(inst); k++)
            for (int j = 0; j < ab_of(inst); j++)
                tx_bytes.push_back((j == ab_of(inst) - 1) ? 8'(k + 1) : 8'h00);
    endtask

    task automatic load_random(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
    endtask

    task automatic reset_dut(input int inst);
        rst_v[inst] = 1'b1;
        sin_v[inst] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_v[inst] = 1'b0;
    endtask

    task automatic chk_zero(input string nm, input int inst);
        chk({nm, "_valid"}, inst, 64'(valid_v[inst]), 64'd0);
        chk({nm, "_args"}, inst, args_v[inst], 64'd0);
        chk({nm, "_op"}, inst, 64'(op_v[inst]), 64'd0);
        chk({nm, "_status"}, inst, 64'(st_v[inst]), 64'd0);
        chk({nm, "_ovf"}, inst, 64'(ovf_v[inst]), 64'd0);
    endtask

    exp_t held [2];
    bit   hold [2];

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst_v[i]) begin
                hold[i] = 1'b0;
            end else begin
                if (hold[i]) begin
                    chk("stall_valid", i, 64'(valid_v[i]), 64'd1);
                    chk("stall_args", i, args_v[i], held[i].args);
                    chk("stall_op", i, 64'(op_v[i]), 64'(held[i].op));
                    chk("stall_status", i, 64'(st_v[i]), 64'(held[i].st));
                end
                if (valid_v[i] && rdy_v[i]) begin
                    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_packet inst%0d: got status %b, expected no packet", i, st_v[i]);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        chk("pkt_args", i, args_v[i], e.args);
                        chk("pkt_op", i, 64'(op_v[i]), 64'(e.op));
                        chk("pkt_status", i, 64'(st_v[i]), 64'(e.st));
                        pop_cyc[i] = cyc;
                    end
                end
                hold[i] = valid_v[i] && !rdy_v[i];
                held[i].args = args_v[i];
                held[i].op   = op_v[i];
                held[i].st   = st_v[i];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        int n;
        int bad;
        logic [3:0] flip;
        bit saw;
        for (int i = 0; i < 2; i++) begin
            sin_v[i] = 1'b1;
            rdy_v[i] = 1'b1;
            rst_v[i] = 1'b1;
            hold[i] = 1'b0;
            pop_cyc[i] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        chk_zero("reset", 0);
        chk_zero("reset", 1);

        for (int i = 0; i < 2; i++) begin
            total = na_of(i) * ab_of(i);
            load_counting(i);
            pop_cyc[i] = -1;
            send_pkt(i, 3'b100, 4'h0, -1, 1'b1, 0);
            chk("cmd_latency", i, 64'(pop_cyc[i] - stop_cyc), 64'd1);
            load_counting(i);
            send_pkt(i, 3'b100, 4'h1, -1, 1'b1, 0);
            load_counting(i);
            send_pkt(i, 3'b110, 4'h0, -1, 1'b1, 0);
            load_counting(i);
            void'(tx_bytes.pop_back());
            send_pkt(i, 3'b100, 4'h0, -1, 1'b1, 0);
            load_counting(i);
            send_pkt(i, 3'b100, 4'h0, 3, 1'b1, 0);
            load_counting(i);
            tx_bytes.push_back(8'hAA);
            send_pkt(i, 3'b101, 4'h0, -1, 1'b1, 0);
            for (int r = 0; r < 20; r++) begin
                n = total;
                if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 0) ? total - 1 : total + 1;
                load_random(n);
                flip = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
                send_pkt(i, 3'($urandom_range(0, 7)), flip, bad, 1'b1, 0);
            end
        end

        // back-pressure: first packet held, second dropped
        rdy_v[0] = 1'b0;
        load_counting(0);
        send_pkt(0, 3'b100, 4'h0, -1, 1'b1, 0);
        chk("bp_valid_held", 0, 64'(valid_v[0]), 64'd1);
        load_random(8);
        send_pkt(0, 3'b101, 4'h0, -1, 1'b0, 0);
        chk("bp_ovf_set", 0, 64'(ovf_v[0]), 64'd1);
        rdy_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_slot_empty", 0, 64'(valid_v[0]), 64'd0);
        chk("bp_queue_drained", 0, 64'(q0.size()), 64'd0);
        reset_dut(0);
        chk_zero("bp_reset", 0);

        // reset in the middle of arg 1
        load_random(8);
        for (int i = 0; i < 5; i++) send_frame(0, 1'b0, tx_bytes[i], 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        reset_dut(0);
        chk_zero("midreset", 0);
        load_random(8);
        send_pkt(0, 3'b001, 4'h0, -1, 1'b1, 0);

        // stall after three data frames
        load_random(8);
        for (int i = 0; i < 3; i++) send_frame(0, 1'b0, tx_bytes[i], 1'b1);
`ifdef ALU_RX_TIMEOUT_EN
        push_exp(0, model_args(0, 3), 3'b000, 3'b001);
        pop_cyc[0] = -1;
        for (int k = 0; k < 200 && q0.size() != 0; k++) @(negedge clk);
        chk("timeout_latency", 0, 64'(pop_cyc[0] - stop_cyc), 64'd65);
`else
        saw = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (valid_v[0]) saw = 1'b1;
        end
        chk("no_timeout", 0, 64'(saw), 64'd0);
        @(posedge clk);
        #1;
        send_pkt(0, 3'b000, 4'h0, -1, 1'b1, 3);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue", 0, 64'(q0.size()), 64'd0);
        chk("final_queue", 1, 64'(q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
